// File: rtl/histogram_percentile_scanner.sv
// histogram_percentile_scanner: one pass over the cumulative histogram RAM per frame,
// resolving the 25/50/75 percentile grey levels and publishing them atomically at scan end.
module histogram_percentile_scanner #(
  parameter int CNT_W  = 20,
  parameter int RD_LAT = 2
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [CNT_W-1:0] iTotal,
  output logic [7:0]       oRdAddr,
  input  logic [CNT_W-1:0] iRdData,
  output logic [7:0]       oThresh25,
  output logic [7:0]       oThresh50,
  output logic [7:0]       oThresh75,
  output logic             oBusy,
  output logic             oDone
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, UPDATE} state_t;
  state_t             state_q;
  logic [7:0]         cnt_q;
  logic [7:0]         rd_addr_q;
  logic               addr_vld_q;
  logic [RD_LAT-1:0]  tag_vld_q;
  logic [7:0]         tag_addr_q [RD_LAT];
  logic [CNT_W-1:0]   tgt_q [3];
  logic [2:0]         found_q;
  logic [7:0]         cand_q [3];
  logic [7:0]         thr_q [3];
  logic               busy_q;
  logic               done_q;
  logic [2:0]         hit_d;
  // Guarding with the tag valid bit keeps an undriven read bus out of the compare.
  always_comb begin
    hit_d = '0;
    for (int p = 0; p < 3; p++)
      hit_d[p] = tag_vld_q[RD_LAT-1] && !found_q[p] && (iRdData >= tgt_q[p]);
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      addr_vld_q <= 1'b0;
      tag_vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_addr_q[i] <= '0;
      for (int p = 0; p < 3; p++) begin
        tgt_q[p]  <= '0;
        cand_q[p] <= '0;
      end
      found_q <= '0;
      thr_q[0] <= 8'd64;
      thr_q[1] <= 8'd128;
      thr_q[2] <= 8'd192;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      tag_vld_q[0]  <= addr_vld_q;
      tag_addr_q[0] <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
      for (int p = 0; p < 3; p++)
        if (hit_d[p]) begin
          found_q[p] <= 1'b1;
          cand_q[p]  <= tag_addr_q[RD_LAT-1];
        end
      case (state_q)
        IDLE: begin
          rd_addr_q <= '0;
          if (iStart && !done_q) begin
            tgt_q[0] <= iTotal >> 2;
            tgt_q[1] <= iTotal >> 1;
            tgt_q[2] <= (iTotal >> 1) + (iTotal >> 2);
            found_q  <= '0;
            for (int p = 0; p < 3; p++) cand_q[p] <= 8'hff;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          rd_addr_q  <= cnt_q;
          addr_vld_q <= 1'b1;
          cnt_q      <= cnt_q + 8'd1;
          if (&cnt_q) state_q <= DRAIN;
        end
        DRAIN: begin
          rd_addr_q  <= '0;
          addr_vld_q <= 1'b0;
          if (!addr_vld_q && !(|tag_vld_q)) state_q <= UPDATE;
        end
        UPDATE: begin
          for (int p = 0; p < 3; p++) thr_q[p] <= cand_q[p];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign oRdAddr   = rd_addr_q;
  assign oThresh25 = thr_q[0];
  assign oThresh50 = thr_q[1];
  assign oThresh75 = thr_q[2];
  assign oBusy     = busy_q;
  assign oDone     = done_q;
endmodule

// File: doc/histogram_percentile_scanner.md
# histogram_percentile_scanner

Scans the 256-bin cumulative grey-level histogram RAM once per frame after accumulation completes. Finds the 25th, 50th and 75th percentile grey levels. Sits between the histogram accumulator and the consumers of the threshold outputs: the single-level thresholder, the multi-level thresholder and the histogram displayer. Threshold outputs stay constant for a whole frame and change atomically at scan end.

## Interface
- `CNT_W`, default 20: width of pixel counts and cumulative histogram words.
- `RD_LAT`, default 2: fixed read latency of the cumulative RAM, in cycles. Legal range is 1..4.
- `iClk` in 1: pixel clock; all logic on rising edge.
- `iRst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `iStart` in 1: single-cycle pulse; cumulative RAM is complete and stable until `oDone`.
- `iTotal` in CNT_W: pixel count of the frame; sampled with `iStart`.
- `oRdAddr` out 8: cumulative RAM read address, registered.
- `iRdData` in CNT_W: cumulative count for the address issued RD_LAT cycles earlier.
- `oThresh25` out 8: 25th percentile grey level.
- `oThresh50` out 8: 50th percentile grey level.
- `oThresh75` out 8: 75th percentile grey level.
- `oBusy` out 1: high while a scan is in progress.
- `oDone` out 1: one-cycle pulse; the threshold outputs were updated on this edge.

## Operation
- **Reset values:**
  - `oThresh25`/`50`/`75` = 8'd64 / 8'd128 / 8'd192.
  - `oRdAddr` = 0, `oBusy` = 0, `oDone` = 0.
  - All internal found flags, candidates and state are cleared; state = IDLE.
- **States:** IDLE → SCAN → DRAIN → UPDATE → IDLE.
- **IDLE:**
  - `oRdAddr` is held at 0.
  - When `iStart`=1, latch the targets:
    - t25 = iTotal>>2
    - t50 = iTotal>>1
    - t75 = (iTotal>>1)+(iTotal>>2)
  - All arithmetic is CNT_W wide, unsigned, and truncating; no overflow is possible.
  - Clear the found flags, set the candidates to 255, and go to SCAN.
- **SCAN:**
  - Issue `oRdAddr` 0,1,…,255 on consecutive cycles.
  - A tag pipe of depth RD_LAT carries the address and a valid bit alongside the RAM read.
  - After address 255 is issued, go to DRAIN.
- **Compare (every returning valid tag):**
  - For each percentile p whose found flag is clear: if `iRdData` >= tp, candidate_p = tag address and set the flag.
  - The first bin satisfying the condition wins; later bins are ignored.
- **DRAIN:** wait until the tag pipe is empty (RD_LAT cycles), then go to UPDATE.
- **UPDATE (one cycle):**
  - Copy the three candidates to the outputs and pulse `oDone`.
  - Return to IDLE.
- **Boundary behaviour:**
  - `iTotal`=0: all targets are 0, so bin 0 matches and all outputs = 0.
  - Cumulative data never reaches a target (incomplete histogram): that output = 255.
  - Equal targets (e.g. `iTotal` < 4): several percentiles may resolve to the same bin; this is legal.
  - `iStart` while `oBusy`=1 (including the UPDATE cycle): ignored, no queuing.
  - `iStart` in the same cycle as `oDone`: ignored.
  - Asynchronous reset mid-scan: immediate return to reset values. No `oDone` is issued, and outputs revert to 64/128/192.
- `iRdData` is sampled only when the tag valid bit is set; X on `iRdData` at other times must not propagate.

## Timing
- Let E0 be the edge that samples `iStart`=1.
- `oBusy` rises at E0.
- `oRdAddr` = k during the cycle after edge E0+1+k, for k = 0..255.
- Data for address k is compared at edge E0+2+k+RD_LAT.
- UPDATE occupies the cycle after edge E0+258+RD_LAT.
- At the following edge, E0+259+RD_LAT:
  - thresholds update,
  - `oDone` pulses,
  - `oBusy` falls, so `oBusy` is already low while `oDone` is high.
- Scan length is fixed at 259+RD_LAT cycles (261 with the default), independent of the data.
- Outputs are glitch-free registers and change only on the `oDone` edge or on reset.
- There is no combinational path from `iRdData` to any output.

## Test plan
- **Uniform histogram:** cum[k]=(k+1)·1500, `iTotal`=384000 → `oThresh25`=63, `oThresh50`=127, `oThresh75`=191. `oDone` arrives exactly 261 cycles after `iStart`.
- **All pixels in bin 200:** cum=0 for k<200 and 384000 for k≥200 → all three outputs = 200. A bench variant sets all pixels in bin 0 → all outputs = 0.
- **Incomplete histogram:** cum saturates at 1000, `iTotal`=384000 → all outputs = 255. Also run `iTotal`=0 with any data → all outputs = 0.
- **Exact-equality boundary:** cum[99]=95999, cum[100]=96000, `iTotal`=384000 → `oThresh25`=100. Checks the >= comparison.
- **`iStart` pulses while busy** (at scan cycles 10 and 200, and on the `oDone` cycle): no restart. Exactly one `oDone` is seen, address sequence 0..255 is unbroken, results are unchanged.
- **Reset mid-scan:** assert `iRst_n`=0 at scan cycle 120 after a previous scan produced 63/127/191. Outputs go immediately to 64/128/192, `oBusy`=0, and no `oDone` appears. A fresh `iStart` then completes normally. Repeat with RD_LAT=1 and RD_LAT=4 and confirm the 259+RD_LAT scan length.
